// File: rtl/alu.sv
// Single-cycle registered ALU: ten integer operations selected by alu_ctrl,
// result and zero flag captured together on the rising clock edge.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] op,
    output logic        zero
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLL  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_AND  = 4'b1001
    } alu_op_e;

    alu_op_e     ctrl;
    logic        use_sub;
    logic [31:0] b_eff;
    logic [32:0] sum33;
    logic [31:0] sum;
    logic        carry;
    logic        lt_u;
    logic        lt_s;

    logic        shl;
    logic        sh_fill;
    logic [4:0]  shamt;
    logic [31:0] sh_src;
    logic [31:0] sh_rt;
    logic [31:0] sh_out;

    logic [31:0] result_d;
    logic        zero_d;
    logic [31:0] op_q;
    logic        zero_q;

    assign ctrl = alu_op_e'(alu_ctrl);

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Shared adder: SUB and both compares reuse it as a + ~b + 1.
    always_comb begin
        use_sub = (ctrl == OP_SUB) || (ctrl == OP_SLT) || (ctrl == OP_SLTU);
        b_eff   = use_sub ? ~b : b;
        sum33   = {1'b0, a} + {1'b0, b_eff} + {32'd0, use_sub};
        sum     = sum33[31:0];
        carry   = sum33[32];
        // No borrow out of a - b means a >= b unsigned.
        lt_u    = ~carry;
        // Differing signs decide directly; otherwise the difference sign does.
        lt_s    = (a[31] ^ b[31]) ? a[31] : sum[31];
    end

    // One right-shifting barrel; left shifts bit-reverse in and out of it.
    always_comb begin
        shl     = (ctrl == OP_SLL);
        sh_fill = (ctrl == OP_SRA) && a[31];
        shamt   = b[4:0];
        sh_src  = shl ? bit_rev(a) : a;
        sh_rt   = sh_src;
        for (int i = 0; i < 5; i++) begin
            if (shamt[i]) begin
                for (int j = 0; j < 32; j++) begin
                    if (j + (1 << i) < 32) begin
                        sh_rt[j] = sh_rt[j + (1 << i)];
                    end else begin
                        sh_rt[j] = sh_fill;
                    end
                end
            end
        end
        sh_out = shl ? bit_rev(sh_rt) : sh_rt;
    end

    // Result select; unused encodings give zero.
    always_comb begin
        result_d = 32'd0;
        unique case (ctrl)
            OP_ADD:  result_d = sum;
            OP_SUB:  result_d = sum;
            OP_SLL:  result_d = sh_out;
            OP_SLT:  result_d = {31'd0, lt_s};
            OP_SLTU: result_d = {31'd0, lt_u};
            OP_XOR:  result_d = a ^ b;
            OP_SRL:  result_d = sh_out;
            OP_SRA:  result_d = sh_out;
            OP_OR:   result_d = a | b;
            OP_AND:  result_d = a & b;
            default: result_d = 32'd0;
        endcase
        zero_d = (result_d == 32'd0);
    end

    // Output registers; reset wins over the operation sampled this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 32'd0;
            zero_q <= 1'b1;
        end else begin
            op_q   <= result_d;
            zero_q <= zero_d;
        end
    end

    assign op   = op_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, randomized operations
// against a behavioural model, hold-between-edges and reset priority.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] op;
    logic        zero;

    int checks;
    int failures;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .op       (op),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [3:0]  c);
        int unsigned sh;
        sh = y % 32;
        case (c)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x * (32'd1 << sh);
            4'd3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd4: return (x < y) ? 32'd1 : 32'd0;
            4'd5: return x ^ y;
            4'd6: return x / (33'd1 << sh);
            4'd7: return $unsigned($signed(x) >>> sh);
            4'd8: return x | y;
            4'd9: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] c);
        a        = x;
        b        = y;
        alu_ctrl = c;
    endtask

    task automatic run_dir(input string tag, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] c,
                           input logic [31:0] exp);
        apply(x, y, c);
        tick();
        check(tag, op, exp);
        check({tag, "_z"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  c;
        logic [31:0] exp;
        logic [31:0] held;
        checks   = 0;
        failures = 0;

        rst = 1'b1;
        apply(32'h1234_5678, 32'h0000_0001, 4'd0);
        tick();
        check("rst1_op", op, 32'd0);
        check("rst1_z", {31'd0, zero}, 32'd1);
        apply(32'hFFFF_FFFF, 32'h0000_0003, 4'd5);
        tick();
        check("rst2_op", op, 32'd0);
        check("rst2_z", {31'd0, zero}, 32'd1);

        rst = 1'b0;
        run_dir("add", 32'd10, 32'd20, 4'd0, 32'd30);
        run_dir("sub_eq", 32'd20, 32'd20, 4'd1, 32'd0);
        run_dir("sub_wrap", 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF);
        run_dir("add_wrap", 32'hFFFF_FFFF, 32'd2, 4'd0, 32'd1);
        run_dir("slt", 32'hFFFF_FFF6, 32'd2, 4'd3, 32'd1);
        run_dir("sltu", 32'hFFFF_FFF0, 32'd1, 4'd4, 32'd0);
        run_dir("slt_ov", 32'h7FFF_FFFF, 32'h8000_0000, 4'd3, 32'd0);
        run_dir("sll", 32'd1, 32'd2, 4'd2, 32'd4);
        run_dir("srl", 32'h8000_0000, 32'd2, 4'd6, 32'h2000_0000);
        run_dir("sra", 32'h8000_0000, 32'd2, 4'd7, 32'hE000_0000);
        run_dir("sll_b5", 32'd1, 32'h0000_0021, 4'd2, 32'd2);
        run_dir("sra_0", 32'h8000_0001, 32'hFFFF_FFE0, 4'd7, 32'h8000_0001);
        run_dir("srl_31", 32'h8000_0000, 32'd31, 4'd6, 32'd1);
        run_dir("xor", 32'hAAAA_5555, 32'h5555_AAAA, 4'd5, 32'hFFFF_FFFF);
        run_dir("or", 32'h0F0F_0F0F, 32'hF000_0000, 4'd8, 32'hFF0F_0F0F);
        run_dir("and", 32'hFF00_00FF, 32'h0F00_00F0, 4'd9, 32'h0F00_00F0);
        run_dir("undef", 32'd10, 32'd20, 4'd15, 32'd0);

        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = $urandom;
            c = 4'($urandom_range(0, 15));
            if (i % 8 == 0) y = x;
            if (i % 5 == 0) y = y & 32'h0000_003F | (y & 32'hFFFF_FFC0);
            exp = model(x, y, c);
            apply(x, y, c);
            tick();
            check($sformatf("rnd%0d_c%0d", i, c), op, exp);
            check($sformatf("rnd%0d_z", i), {31'd0, zero},
                  {31'd0, exp == 32'd0});
            if (i % 10 == 0) begin
                held = op;
                apply($urandom, $urandom, 4'($urandom_range(0, 9)));
                #3;
                check($sformatf("hold%0d", i), op, held);
            end
        end

        apply(32'd7, 32'd9, 4'd0);
        tick();
        check("pre_rst_add", op, 32'd16);
        rst = 1'b1;
        apply(32'd100, 32'd200, 4'd0);
        tick();
        check("rst_prio_op", op, 32'd0);
        check("rst_prio_z", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        apply(32'd5, 32'd3, 4'd1);
        tick();
        check("post_rst_sub", op, 32'd2);
        check("post_rst_z", {31'd0, zero}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have exactly one clock and a synchronous, active-high reset, and no parameters.
REQ-002 The port list SHALL be exactly:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous reset, active-high
- a  input  32  operand A
- b  input  32  operand B
- alu_ctrl  input  4  operation select
- op  output  32  registered result
- zero  output  1  registered flag, high when op is all zeros

Function
REQ-003 On each rising clk edge with rst low, the block SHALL sample a, b and alu_ctrl, then register the result into op in the same edge.
- Latency: 1 cycle.
- Throughput: one operation per cycle.
- No handshake; new operands are accepted every cycle.
REQ-004 The alu_ctrl encoding SHALL be:
- 0000 ADD: a+b, modulo 2^32
- 0001 SUB: a-b, modulo 2^32
- 0010 SLL: a shifted left by b[4:0]
- 0011 SLT: 1 if signed(a) < signed(b), else 0
- 0100 SLTU: 1 if unsigned(a) < unsigned(b), else 0
- 0101 XOR: a^b
- 0110 SRL: a logically shifted right by b[4:0]
- 0111 SRA: a arithmetically shifted right by b[4:0], sign bit replicated
- 1000 OR: a|b
- 1001 AND: a&b
REQ-005 ADD and SUB SHALL wrap silently; no carry or overflow output exists.
REQ-006 Shift operations SHALL use only b[4:0] and ignore b[31:5]; a shift amount of 0 SHALL return a unchanged.
REQ-007 SLT and SLTU SHALL drive bits [31:1] of op to 0 and place the comparison result in bit 0.
REQ-008 Unused encodings 1010 through 1111 SHALL produce op = 0x00000000 and zero = 1.
REQ-009 The zero output SHALL be registered in the same edge as op and SHALL equal (result == 0), so it is always coherent with op.
REQ-010 The outputs SHALL hold their value between clock edges; inputs that change between edges SHALL NOT affect the outputs until the next edge.

Reset
REQ-011 When rst is high at a rising clk edge, the block SHALL set op to 0x00000000 and zero to 1, regardless of a, b and alu_ctrl.
REQ-012 Reset SHALL take priority over any operation sampled in the same cycle; that operation SHALL be discarded.
REQ-013 On the first rising edge with rst low, the block SHALL resume normal sampling per REQ-003.
REQ-014 The block SHALL hold no state other than the op and zero registers.

Verification
REQ-015 Reset check: assert rst for 2 cycles with arbitrary inputs -> op=0x00000000 and zero=1; deassert rst, apply a=10, b=20, ctrl=0000 -> after 1 edge, op=30 and zero=0.
REQ-016 Arithmetic and compare:
- SUB 20-20 -> op=0, zero=1
- SUB 0-1 -> op=0xFFFFFFFF
- SLT a=-10 (0xFFFFFFF6), b=2 -> op=1
- SLTU a=0xFFFFFFF0, b=1 -> op=0, zero=1
REQ-017 Shifts:
- SLL a=1, b=2 -> op=4
- SRL a=0x80000000, b=2 -> op=0x20000000
- SRA a=0x80000000, b=2 -> op=0xE0000000
- SLL a=1, b=0x00000021 -> op=2 (only b[4:0] used)
REQ-018 Logic:
- XOR 0xAAAA5555 ^ 0x5555AAAA -> op=0xFFFFFFFF
- OR 0x0F0F0F0F | 0xF0000000 -> op=0xFF0F0F0F
- AND 0xFF0000FF & 0x0F0000F0 -> op=0x0F0000F0
REQ-019 Undefined encoding: ctrl=1111, a=10, b=20 -> op=0, zero=1.
REQ-020 Back-to-back and reset priority: change operation every cycle -> each result appears exactly 1 edge after its inputs; assert rst in the same cycle as an ADD -> op=0 and zero=1, and the ADD result never appears.
